// File: rtl/long_arith_pkg.sv
// ============================================================================
// Module   : long_arith_pkg
// Brief    : Shared widths, serializer state type and word-count helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package long_arith_pkg;

  localparam int ACC_SIZE  = 3474;
  localparam int SER_WIDTH = 64;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  function automatic int num_words(input int size, input int width);
    return (size + width - 1) / width;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/long_word_counter.sv
// ============================================================================
// Module   : long_word_counter
// Brief    : Output word index with terminal-count flag; wraps to 0 after last.
// Revision : 1.0
// ============================================================================
`default_nettype none

module long_word_counter #(
  parameter int NUM_WORDS = 55,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  logic [IDX_W-1:0] r_idx;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_idx <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_inc) begin
      r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = w_last;

endmodule

`default_nettype wire

// File: rtl/long_result_serializer.sv
// ============================================================================
// Module   : long_result_serializer
// Brief    : Captures a wide accumulator result and streams it LS word first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module long_result_serializer
  import long_arith_pkg::*;
#(
  parameter  int SIZE      = ACC_SIZE,
  parameter  int WIDTH     = SER_WIDTH,
  localparam int NUM_WORDS = num_words(SIZE, WIDTH),
  localparam int IDX_W     = idx_width(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [SIZE-1:0]  din,
  input  logic             load,
  output logic             busy,
  output logic             overrun,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic [IDX_W-1:0] dout_idx
);

  localparam int PAD_W = NUM_WORDS * WIDTH;

  ser_state_t       r_state;
  ser_state_t       w_state_next;
  logic [PAD_W-1:0] r_shreg;
  logic             r_overrun;
  logic             w_overrun_next;
  logic             w_capture;
  logic             w_shift;
  logic             w_hs;
  logic             w_valid;
  logic             w_last;
  logic [IDX_W-1:0] w_idx;

  assign w_valid = (r_state == SEND);
  assign w_hs    = w_valid && dout_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= IDLE;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_overrun <= w_overrun_next;
    end
  end

  // A load coinciding with the final handshake starts the next stream without a bubble.
  always_comb begin
    w_state_next   = r_state;
    w_capture      = 1'b0;
    w_shift        = 1'b0;
    w_overrun_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_capture    = 1'b1;
          w_state_next = SEND;
        end
      end
      SEND: begin
        if (w_hs && w_last) begin
          if (load) begin
            w_capture = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end else begin
          w_shift        = w_hs;
          w_overrun_next = load;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Data bits carry no reset; the output gate hides them whenever idle.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_shreg <= PAD_W'(din);
    end else if (w_shift) begin
      r_shreg <= r_shreg >> WIDTH;
    end
  end

  long_word_counter #(
    .NUM_WORDS (NUM_WORDS),
    .IDX_W     (IDX_W)
  ) u_word_counter (
    .clk    (clk),
    .arst   (arst),
    .i_clr  (w_capture),
    .i_inc  (w_hs),
    .o_idx  (w_idx),
    .o_last (w_last)
  );

  assign busy       = w_valid;
  assign dout_valid = w_valid;
  assign dout       = r_shreg[WIDTH-1:0] & {WIDTH{w_valid}};
  assign dout_last  = w_last & w_valid;
  assign dout_idx   = w_idx & {IDX_W{w_valid}};
  assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_long_result_serializer.sv
// ============================================================================
// Module   : tb_long_result_serializer
// Brief    : Scoreboard bench for long_result_serializer at SIZE=3474, WIDTH=64.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_long_result_serializer;

  localparam int SIZE  = 3474;
  localparam int WIDTH = 64;
  localparam int NW    = 55;
  localparam int IDX_W = 6;
  localparam int PAD_W = NW * WIDTH;

  typedef struct {
    logic [WIDTH-1:0] word;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  typedef struct {
    logic [SIZE-1:0]  din;
    int               mode;
    logic [WIDTH-1:0] exp_last;
    int               exp_cycles;
  } vec_t;

  logic             clk = 1'b0;
  logic             arst;
  logic [SIZE-1:0]  din;
  logic             load;
  logic             busy;
  logic             overrun;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic [IDX_W-1:0] dout_idx;

  int               n_checks = 0;
  int               n_fail   = 0;
  exp_t             sb[$];
  logic [WIDTH-1:0] last_word_seen;
  bit               stall_prev = 0;
  logic [WIDTH-1:0] prev_dout;
  logic [IDX_W-1:0] prev_idx;

  long_result_serializer #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .load       (load),
    .busy       (busy),
    .overrun    (overrun),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .dout_idx   (dout_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] rand_din();
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic push_words(input logic [SIZE-1:0] d);
    logic [PAD_W-1:0] p;
    exp_t e;
    p = PAD_W'(d);
    for (int k = 0; k < NW; k++) begin
      e.word = p[k*WIDTH +: WIDTH];
      e.idx  = IDX_W'(k);
      e.last = (k == NW - 1);
      sb.push_back(e);
    end
  endtask

  // Scoreboard consumer plus hold-while-stalled check.
  always @(negedge clk) begin
    if (arst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (!(dout_valid && dout == prev_dout && dout_idx == prev_idx)) begin
          n_fail++;
          $display("FAIL hold: got v=%b d=%h i=%0d expected v=1 d=%h i=%0d",
                   dout_valid, dout, dout_idx, prev_dout, prev_idx);
        end
      end
      if (dout_valid && dout_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %h idx %0d expected no word", dout, dout_idx);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (dout !== e.word || dout_idx !== e.idx || dout_last !== e.last) begin
            n_fail++;
            $display("FAIL word: got %h idx %0d last %b expected %h idx %0d last %b",
                     dout, dout_idx, dout_last, e.word, e.idx, e.last);
          end
          if (dout_last) last_word_seen = dout;
        end
      end
      stall_prev = dout_valid && !dout_ready;
      prev_dout  = dout;
      prev_idx   = dout_idx;
    end
  end

  // Captures d, streams it, optionally drives a second load at cycle xl_cycle.
  task automatic run_stream(input logic [SIZE-1:0] d, input int mode, input int xl_cycle,
                            input logic [SIZE-1:0] xd, input bit x_cap,
                            output int cycles, output int first_last);
    int stalls;
    int n_last;
    int pushed;
    push_words(d);
    din  = d;
    load = 1'b1;
    @(posedge clk); #1;
    cycles = 0; stalls = 0; n_last = 0; pushed = NW; first_last = -1;
    while (sb.size() > 0 && cycles < 1000) begin
      cycles++;
      case (mode)
        0:       dout_ready = 1'b1;
        1:       dout_ready = ((cycles - 1) % 4 == 0) || ((cycles - 1) % 4 == 3);
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
      if (cycles == xl_cycle) begin
        load = 1'b1;
        din  = xd;
        if (x_cap) begin
          push_words(xd);
          pushed += NW;
        end
      end else begin
        load = 1'b0;
        din  = rand_din();
      end
      @(negedge clk);
      check("busy_stream", WIDTH'(busy), 1);
      check("overrun", WIDTH'(overrun), WIDTH'(xl_cycle > 0 && !x_cap && cycles == xl_cycle + 1));
      if (dout_valid && !dout_ready) stalls++;
      if (dout_last && dout_ready) begin
        n_last++;
        if (first_last < 0) first_last = cycles;
      end
      @(posedge clk); #1;
    end
    load = 1'b0;
    check("stream_done", WIDTH'(sb.size()), 0);
    check("total_cycles", WIDTH'(cycles), WIDTH'(pushed + stalls));
    check("last_count", WIDTH'(n_last), WIDTH'(pushed / NW));
    @(negedge clk);
    check("busy_after", WIDTH'(busy), 0);
    check("valid_after", WIDTH'(dout_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t            vecs[5];
    logic [SIZE-1:0] tmp;
    int              cyc;
    int              fl;
    int              guard;

    arst = 1'b1; load = 1'b0; din = '0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 0);
    check("rst_valid", WIDTH'(dout_valid), 0);
    check("rst_busy", WIDTH'(busy), 0);
    check("rst_overrun", WIDTH'(overrun), 0);
    check("rst_last", WIDTH'(dout_last), 0);
    check("rst_idx", WIDTH'(dout_idx), 0);
    #2 arst = 1'b0;

    dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_valid", WIDTH'(dout_valid), 0);
    check("idle_ready_idx", WIDTH'(dout_idx), 0);

    tmp = '0; tmp[SIZE-1] = 1'b1;
    vecs[0] = '{tmp, 0, 64'h20000, 55};
    tmp = rand_din();
    vecs[1] = '{tmp, 1, WIDTH'(tmp >> (54 * WIDTH)), -1};
    tmp = '1;
    vecs[2] = '{tmp, 0, 64'h3FFFF, 55};
    tmp = rand_din();
    vecs[3] = '{tmp, 2, WIDTH'(tmp >> (54 * WIDTH)), -1};
    tmp = '0;
    vecs[4] = '{tmp, 0, 64'h0, 55};

    for (int v = 0; v < 5; v++) begin
      run_stream(vecs[v].din, vecs[v].mode, -1, '0, 1'b0, cyc, fl);
      check("last_word", last_word_seen, vecs[v].exp_last);
      if (vecs[v].exp_cycles > 0) begin
        check("cycles_nostall", WIDTH'(cyc), WIDTH'(vecs[v].exp_cycles));
        check("last_cycle", WIDTH'(fl), 55);
      end
    end

    // Back-to-back: B loaded coincident with A's last handshake.
    run_stream(rand_din(), 0, 55, rand_din(), 1'b1, cyc, fl);
    check("b2b_cycles", WIDTH'(cyc), 110);

    // Overrun: load dropped while idx == 10.
    run_stream(rand_din(), 0, 11, rand_din(), 1'b0, cyc, fl);
    check("ovr_cycles", WIDTH'(cyc), 55);

    // Async reset between clock edges at idx == 20.
    tmp = rand_din();
    push_words(tmp);
    din = tmp; load = 1'b1; dout_ready = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (dout_idx != 20 && guard < 100);
    check("reach_idx20", WIDTH'(dout_idx), 20);
    #2 arst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_valid", WIDTH'(dout_valid), 0);
    check("arst_busy", WIDTH'(busy), 0);
    check("arst_idx", WIDTH'(dout_idx), 0);
    check("arst_last", WIDTH'(dout_last), 0);
    sb.delete();
    @(posedge clk); #2;
    arst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", WIDTH'(dout_valid), 0);
    run_stream(rand_din(), 0, -1, '0, 1'b0, cyc, fl);
    check("post_rst_cycles", WIDTH'(cyc), 55);
    check("post_rst_last", WIDTH'(fl), 55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
